// File: rtl/fishing_game_ctrl.sv
// Fishing game state controller: button conditioning, LFSR bite delay, tick timing and
// the start/wait/bite/win/lose sequencer feeding the VGA scene renderer.
//
// state   | meaning
// S_START | title screen, waiting for a cast
// S_WAIT  | line cast, counting down the random bite delay
// S_BITE  | fish on the line, catch window running
// S_WIN   | caught, result screen held
// S_LOSE  | reeled early or window missed, result screen held
module fishing_game_ctrl #(
  parameter int          DEBOUNCE_CYCLES    = 250000,
  parameter int          TICK_CYCLES        = 250000,
  parameter int          BITE_MIN_TICKS     = 100,
  parameter int          BITE_RANGE_LOG2    = 8,
  parameter int          CATCH_WINDOW_TICKS = 50,
  parameter int          RESULT_TICKS       = 300,
  parameter logic [15:0] LFSR_SEED          = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_cast,
  input  logic       btn_reel,
  output logic [1:0] game_state,
  output logic       rod_pos,
  output logic       bite,
  output logic [7:0] score
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam logic [7:0] RANGE_MASK = 8'((1 << BITE_RANGE_LOG2) - 1);

  localparam logic [2:0] S_START = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_BITE  = 3'd2;
  localparam logic [2:0] S_WIN   = 3'd3;
  localparam logic [2:0] S_LOSE  = 3'd4;

  logic [1:0]    raw, sync1, sync2, deb, deb_q, press;
  logic [DW-1:0] db_cnt [2];
  logic          cast_p, reel_p;

  assign raw    = {btn_reel, btn_cast};
  assign cast_p = press[0];
  assign reel_p = press[1];

  // Index 0 is cast, index 1 is reel; press is a registered rising edge of the debounced level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= '0;
      sync2     <= '0;
      deb       <= '0;
      deb_q     <= '0;
      press     <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      press <= deb & ~deb_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt[i] <= '0;
          deb[i]    <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr <= LFSR_SEED;
    else if (lfsr[0]) lfsr <= {1'b0, lfsr[15:1]} ^ 16'hB400;
    else lfsr <= {1'b0, lfsr[15:1]};
  end

  logic [2:0]    state, state_next;
  logic [TW-1:0] tick_cnt;
  logic [15:0]   elapsed, bite_delay;
  logic          tick, st_chg;
  logic [1:0]    gs_next;

  assign tick   = (tick_cnt == TW'(TICK_CYCLES - 1));
  assign st_chg = (state_next != state);

  always_comb begin
    state_next = state;
    case (state)
      S_START: if (cast_p) state_next = S_WAIT;
      S_WAIT: begin
        if (reel_p) state_next = S_LOSE;
        else if (elapsed == bite_delay) state_next = S_BITE;
      end
      S_BITE: begin
        if (reel_p) state_next = S_WIN;
        else if (elapsed == 16'(CATCH_WINDOW_TICKS)) state_next = S_LOSE;
      end
      S_WIN, S_LOSE: begin
        if (cast_p || elapsed == 16'(RESULT_TICKS)) state_next = S_START;
      end
      default: state_next = S_START;
    endcase
  end

  always_comb begin
    gs_next = 2'b00;
    case (state_next)
      S_WAIT, S_BITE: gs_next = 2'b01;
      S_WIN:          gs_next = 2'b10;
      S_LOSE:         gs_next = 2'b11;
      default:        gs_next = 2'b00;
    endcase
  end

  // Timers restart on every state change so each state measures from its own entry edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_START;
      tick_cnt   <= '0;
      elapsed    <= '0;
      bite_delay <= '0;
      game_state <= 2'b00;
      rod_pos    <= 1'b0;
      bite       <= 1'b0;
      score      <= 8'd0;
    end else begin
      state <= state_next;
      if (st_chg) begin
        tick_cnt <= '0;
        elapsed  <= '0;
      end else if (tick) begin
        tick_cnt <= '0;
        elapsed  <= elapsed + 16'd1;
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
      if (state == S_START && cast_p)
        bite_delay <= 16'(BITE_MIN_TICKS) + {8'h00, lfsr[7:0] & RANGE_MASK};
      game_state <= gs_next;
      rod_pos    <= (state_next == S_BITE);
      bite       <= (state_next == S_BITE);
      if (state == S_BITE && state_next == S_WIN && score != 8'hFF)
        score <= score + 8'd1;
    end
  end

endmodule

// File: tb/tb_fishing_game_ctrl.sv
// Directed bench for fishing_game_ctrl: expected output events are queued when stimulus
// is driven and popped as the DUT changes its outputs.
module tb_fishing_game_ctrl;

  localparam int          D    = 4;
  localparam int          T    = 2;
  localparam int          BMIN = 3;
  localparam int          BLOG = 2;
  localparam int          CW   = 4;
  localparam int          RT   = 5;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          LAT  = D + 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_cast = 1'b0;
  logic       btn_reel = 1'b0;
  logic [1:0] game_state;
  logic       rod_pos, bite;
  logic [7:0] score;

  fishing_game_ctrl #(
    .DEBOUNCE_CYCLES(D), .TICK_CYCLES(T), .BITE_MIN_TICKS(BMIN), .BITE_RANGE_LOG2(BLOG),
    .CATCH_WINDOW_TICKS(CW), .RESULT_TICKS(RT), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .btn_cast(btn_cast), .btn_reel(btn_reel),
    .game_state(game_state), .rod_pos(rod_pos), .bite(bite), .score(score)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  int vectors = 0;
  int errors  = 0;
  int sc      = 0;

  typedef struct {
    logic [1:0] gs;
    logic       bt;
    logic [7:0] scr;
    int         at;
  } exp_t;
  exp_t sb[$];

  function automatic logic [15:0] lfsr_after(input int n);
    logic [15:0] v = SEED;
    for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    return v;
  endfunction

  // bite_delay latched on the edge that enters WAIT (edge k), using the LFSR value before it
  function automatic int delay_for(input int k);
    logic [15:0] v = lfsr_after(k - 1);
    logic [15:0] m = 16'((1 << BLOG) - 1);
    return BMIN + int'(v & m);
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  function automatic logic [11:0] snap();
    return {game_state, bite, rod_pos, score};
  endfunction

  task automatic wait_change(input int budget, output bit ok);
    logic [11:0] s0;
    s0 = snap();
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (snap() !== s0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic push(input logic [1:0] gs, input logic bt, input int scr, input int at);
    exp_t e;
    e.gs = gs; e.bt = bt; e.scr = 8'(scr); e.at = at;
    sb.push_back(e);
  endtask

  task automatic expect_next(input string name, input int budget);
    bit   ok;
    exp_t e;
    wait_change(budget, ok);
    check({name, "_seen"}, 32'(ok), 32'd1);
    check({name, "_queued"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({name, "_state"}, 32'(game_state), 32'(e.gs));
      check({name, "_bite"},  32'(bite),       32'(e.bt));
      check({name, "_rod"},   32'(rod_pos),    32'(e.bt));
      check({name, "_score"}, 32'(score),      32'(e.scr));
      check({name, "_cycle"}, 32'(cyc),        32'(e.at));
    end
  endtask

  task automatic idle_check(input string name, input int budget);
    bit ok;
    wait_change(budget, ok);
    check(name, 32'(ok), 32'd0);
  endtask

  // Cast from START and follow through WAIT into BITE; b is the cycle BITE was entered.
  task automatic to_bite(input string name, output int b);
    int c, k, d;
    c = cyc; k = c + LAT; d = delay_for(k);
    btn_cast = 1'b1;
    push(2'b01, 1'b0, sc, k);
    push(2'b01, 1'b1, sc, k + d * T + 1);
    expect_next({name, "_wait"}, 40);
    btn_cast = 1'b0;
    expect_next({name, "_bite"}, 60);
    b = cyc;
  endtask

  initial begin
    int c, k, d, r, b, w, l, spur;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_state", 32'(game_state), 32'd0);
    check("rst_rod",   32'(rod_pos),    32'd0);
    check("rst_bite",  32'(bite),       32'd0);
    check("rst_score", 32'(score),      32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle_check("idle_after_reset", 100);

    // bouncing cast ends low, then steady high
    spur = 0;
    for (int i = 0; i < 10; i++) begin
      btn_cast = (i % 2 == 0);
      repeat (2) begin
        @(negedge clk);
        if (game_state !== 2'b00) spur++;
      end
    end
    check("bounce_no_early", 32'(spur), 32'd0);
    btn_cast = 1'b1;
    c = cyc; k = c + LAT; d = delay_for(k);
    push(2'b01, 1'b0, sc, k);
    push(2'b01, 1'b1, sc, k + d * T + 1);
    expect_next("bounce_cast", 40);
    btn_cast = 1'b0;
    expect_next("win_bite_rise", 60);
    b = cyc;
    btn_reel = 1'b1;
    sc = sc + 1;
    push(2'b10, 1'b0, sc, b + LAT);
    expect_next("win_reel", 20);
    w = cyc;
    btn_reel = 1'b0;
    push(2'b00, 1'b0, sc, w + RT * T + 1);
    expect_next("win_timeout", 30);

    repeat (10) @(negedge clk);
    btn_cast = 1'b1;
    repeat (3) @(negedge clk);
    btn_cast = 1'b0;
    idle_check("glitch_ignored", 30);

    // early reel: reel press lands one cycle after WAIT entry
    c = cyc; k = c + LAT;
    btn_cast = 1'b1;
    @(negedge clk);
    btn_reel = 1'b1;
    push(2'b01, 1'b0, sc, k);
    push(2'b11, 1'b0, sc, k + 1);
    expect_next("early_cast", 20);
    expect_next("early_lose", 5);
    l = cyc;
    btn_cast = 1'b0;
    btn_reel = 1'b0;
    push(2'b00, 1'b0, sc, l + RT * T + 1);
    expect_next("lose_timeout", 30);

    // reel press on the very cycle the bite delay is reached
    repeat (10) @(negedge clk);
    c = cyc; k = c + LAT; d = delay_for(k); r = k + d * T + 1 - LAT;
    push(2'b01, 1'b0, sc, k);
    push(2'b11, 1'b0, sc, k + d * T + 1);
    btn_cast = 1'b1;
    repeat (6) @(negedge clk);
    btn_cast = 1'b0;
    if (r < k) begin
      while (cyc < r) @(negedge clk);
      btn_reel = 1'b1;
      expect_next("tie_delay_wait", 20);
    end else begin
      expect_next("tie_delay_wait", 20);
      while (cyc < r) @(negedge clk);
      btn_reel = 1'b1;
    end
    expect_next("tie_delay_lose", 40);
    l = cyc;
    btn_reel = 1'b0;
    btn_cast = 1'b1;
    push(2'b00, 1'b0, sc, l + LAT);
    expect_next("cast_abort", 20);
    btn_cast = 1'b0;

    repeat (10) @(negedge clk);
    to_bite("expire", b);
    push(2'b11, 1'b0, sc, b + CW * T + 1);
    expect_next("window_expire", 20);
    push(2'b00, 1'b0, sc, cyc + RT * T + 1);
    expect_next("expire_timeout", 30);

    // reel pulse coincides with window expiry
    repeat (10) @(negedge clk);
    to_bite("tie_win", b);
    @(negedge clk);
    btn_reel = 1'b1;
    sc = sc + 1;
    push(2'b10, 1'b0, sc, b + CW * T + 1);
    expect_next("tie_window_win", 20);
    btn_reel = 1'b0;
    push(2'b00, 1'b0, sc, cyc + RT * T + 1);
    expect_next("tie_win_timeout", 30);

    repeat (10) @(negedge clk);
    to_bite("rst_bite", b);
    #2 reset = 1'b0;
    #1;
    check("midrst_state", 32'(game_state), 32'd0);
    check("midrst_rod",   32'(rod_pos),    32'd0);
    check("midrst_bite",  32'(bite),       32'd0);
    check("midrst_score", 32'(score),      32'd0);
    sc = 0;
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 256; i++) begin
      repeat (10) @(negedge clk);
      to_bite("sat", b);
      btn_reel = 1'b1;
      if (sc < 255) sc = sc + 1;
      push(2'b10, 1'b0, sc, b + LAT);
      expect_next("sat_win", 20);
      btn_reel = 1'b0;
      push(2'b00, 1'b0, sc, cyc + RT * T + 1);
      expect_next("sat_timeout", 30);
    end
    check("sat_final_score", 32'(score), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fishing_game_ctrl.md
# fishing_game_ctrl

Game-state controller for the fishing game. It sits directly upstream of the VGA scene renderer and produces the `game_state` and `rod_pos` signals that select the displayed scene. It debounces the two player buttons and runs the start / fish / win / lose state machine, with a pseudo-random bite delay and a timed catch window. It runs on the same 25 MHz pixel clock as the renderer, so no clock-domain crossing is needed on its outputs.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000: number of consecutive stable cycles before a button's debounced level changes (10 ms).
- `TICK_CYCLES`, default 250000: cycles per game tick (10 ms).
- `BITE_MIN_TICKS`, default 100: minimum wait from cast to bite.
- `BITE_RANGE_LOG2`, default 8: random extra wait is 0..2^N−1 ticks, N ≤ 8.
- `CATCH_WINDOW_TICKS`, default 50: length of the bite window during which reeling wins.
- `RESULT_TICKS`, default 300: how long the win/lose screen is held.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk`  in  1  25 MHz clock.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_cast`  in  1  raw, asynchronous, active-high cast button.
- `btn_reel`  in  1  raw, asynchronous, active-high reel button.
- `game_state`  out  2  00 start, 01 fish, 10 win, 11 lose.
- `rod_pos`  out  1  1 while a fish is on the line (BITE state only).
- `bite`  out  1  bite indicator; identical to `rod_pos`, kept for the sound/LED logic.
- `score`  out  8  count of wins; saturates at 255.

## Operation
- **Input conditioning, per button:**
  - 2-flop synchronizer.
  - Debounce counter: the debounced level takes the synced value after DEBOUNCE_CYCLES consecutive cycles of disagreement. Any agreement clears the counter.
  - A press is a 1-cycle pulse on a debounced 0→1 transition. Releases generate no event.
- **LFSR:** 16-bit Galois, mask 16'hB400, advances every cycle, never reaches zero.
- **Tick generator:**
  - Counter runs 0..TICK_CYCLES−1; `tick` pulses on the cycle the counter wraps.
  - The tick counter and the 16-bit elapsed-tick counter both clear on every FSM state change.
- **FSM states:** START, WAIT, BITE, WIN, LOSE. WAIT and BITE both drive `game_state`=01.
  - **START:** cast press → WAIT. On the same edge, latch `bite_delay` = BITE_MIN_TICKS + lfsr[BITE_RANGE_LOG2−1:0]. Reel presses are ignored.
  - **WAIT:**
    - Reel press → LOSE (reeled too early).
    - Otherwise, when elapsed ticks == `bite_delay` → BITE.
    - Cast presses are ignored.
  - **BITE:**
    - Reel press → WIN; `score` increments, saturating at 255.
    - Otherwise, when elapsed ticks == CATCH_WINDOW_TICKS → LOSE.
  - **WIN / LOSE:** after elapsed ticks == RESULT_TICKS → START. A cast press → START immediately.
- **Simultaneous events:**
  - Reel press on the same cycle as window expiry: WIN.
  - Reel press on the same cycle as bite-delay reached: LOSE.
  - Cast and reel pressed together in WAIT/BITE: only reel is acted on.
- **Outputs:** all registered and decoded from the state register. `rod_pos` = `bite` = (state == BITE).
- **Reset (async assert, sync release):**
  - State START; `game_state`=00, `rod_pos`=0, `bite`=0, `score`=0.
  - Debounced levels 0, all counters 0, LFSR = LFSR_SEED.
  - A button already held at reset release produces one press after debounce.

## Timing
- **Raw button to `game_state` change:** DEBOUNCE_CYCLES+4 rising edges from the first edge that samples the raw level high (2 sync + debounce + edge pulse + state register).
- **Bite timing:** `bite` rises exactly `bite_delay`×TICK_CYCLES+1 cycles after WAIT entry.
- **Window expiry:** BITE→LOSE occurs CATCH_WINDOW_TICKS×TICK_CYCLES+1 cycles after BITE entry.
- **Result timeout:** WIN/LOSE→START occurs RESULT_TICKS×TICK_CYCLES+1 cycles after entry.
- **Output coherence:** `game_state`, `rod_pos`, `bite` and `score` all change on the same edge as the state transition; there are no combinational paths from inputs to outputs.

## Test plan
All directed tests use DEBOUNCE_CYCLES=4, TICK_CYCLES=2, BITE_MIN_TICKS=3, BITE_RANGE_LOG2=2, CATCH_WINDOW_TICKS=4, RESULT_TICKS=5.

1. **Reset values:** assert reset low mid-run with buttons idle → outputs immediately 00/0/0/0. After release, no transition for 100 cycles.
2. **Bounce rejection:**
   - `btn_cast` toggling every 2 cycles for 20 cycles, then held high → exactly one START→01 transition, 8 edges after the steady level begins.
   - A 3-cycle glitch → no change.
3. **Win path:**
   - Cast → `bite` rises `bite_delay`×2+1 cycles after 01, with `bite_delay` matching the reference LFSR model.
   - Reel press in BITE → `game_state`=10, `score`=1, `rod_pos`=0.
   - 11 cycles later → 00.
4. **Early reel:** reel pressed in WAIT → `game_state`=11, `score` unchanged, `bite` never asserted.
5. **Window expiry and tie-break:**
   - No reel after bite → 11 exactly 9 cycles after BITE entry.
   - Reel press forced on the expiry cycle → 10.
6. **Reset mid-operation and saturation:**
   - Async reset in BITE → 00, `score`=0 with no clock edge.
   - 256 forced wins → `score` holds at 255.
